// File: rtl/aes256_key_sched_ctrl_if.sv
// Key-load handshake, expander link and round-key read port of the AES-256
// key-schedule controller, grouped so the controller and its users share one bundle.
interface aes256_key_sched_ctrl_if #(
  parameter int KW = 256,
  parameter int BW = 128
);
  logic          key_valid;
  logic          key_ready;
  logic [KW-1:0] key_in;
  logic          exp_start;
  logic [KW-1:0] exp_key;
  logic [BW-1:0] exp_subkey;
  logic [3:0]    exp_cnt;
  logic          exp_valid;
  logic          rk_lock;
  logic [3:0]    rk_idx;
  logic [BW-1:0] rk_data;
  logic          keys_ready;
  logic          key_err;

  modport slave (
    input  key_valid, key_in, exp_subkey, exp_cnt, exp_valid, rk_lock, rk_idx,
    output key_ready, exp_start, exp_key, rk_data, keys_ready, key_err
  );

  modport master (
    output key_valid, key_in, exp_subkey, exp_cnt, exp_valid, rk_lock, rk_idx,
    input  key_ready, exp_start, exp_key, rk_data, keys_ready, key_err
  );
endinterface

// File: rtl/aes256_key_sched_ctrl.sv
// Sequences one AES-256 key expansion: accepts the key, kicks the expander,
// collects round keys 0..NR into a buffer and serves them over a registered read port.
module aes256_key_sched_ctrl #(
  parameter int NR = 14,
  parameter int KW = 256,
  parameter int BW = 128
) (
  input logic                     clk,
  input logic                     reset,
  aes256_key_sched_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, START, COLLECT, READY} state_t;

  localparam logic [3:0] LAST = 4'(NR);

  state_t        state;
  logic [3:0]    expected;
  logic [BW-1:0] rk [NR+1];
  logic          accept;

  // The cipher core's lock only withholds acceptance; a running collection carries on.
  assign bus.key_ready = ((state == IDLE) || (state == READY)) && !bus.rk_lock;
  assign accept        = bus.key_valid && bus.key_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      expected       <= '0;
      bus.exp_start  <= 1'b0;
      bus.exp_key    <= '0;
      bus.keys_ready <= 1'b0;
      bus.key_err    <= 1'b0;
      bus.rk_data    <= '0;
      // NOTE: the buffer is reset on purpose so a reload abandoned by reset never leaves stale keys readable.
      for (int i = 0; i <= NR; i++) rk[i] <= '0;
    end else begin
      // NOTE: non-blocking reads here see the pre-edge buffer, so a same-cycle write returns the old value.
      bus.rk_data   <= (bus.rk_idx <= LAST) ? rk[bus.rk_idx] : '0;
      bus.exp_start <= 1'b0;

      case (state)
        IDLE, READY: begin
          if (accept) begin
            bus.exp_key    <= bus.key_in;
            rk[0]          <= bus.key_in[KW-1 -: BW];
            bus.keys_ready <= 1'b0;
            bus.key_err    <= 1'b0;
            bus.exp_start  <= 1'b1;
            state          <= START;
          end
        end
        START: begin
          expected <= 4'd1;
          state    <= COLLECT;
        end
        COLLECT: begin
          if (bus.exp_valid && (bus.exp_cnt == expected)) begin
            rk[bus.exp_cnt] <= bus.exp_subkey;
            expected        <= expected + 4'd1;
            if (bus.exp_cnt == LAST) begin
              bus.keys_ready <= 1'b1;
              state          <= READY;
            end
          end else begin
            // A gap or an out-of-order index breaks the schedule; abandon it.
            bus.key_err <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
